spi_controller: RTL
===================

# spi_controller

SPI mode-0 write initiator: accepts one register-write request per handshake and serialises it as a 16-bit frame on nCS/SCLK/COPI. It drives the chip's SPI peripheral register interface (enables, PWM enables, duty cycle) from on-chip logic. Used as a bench driver and as an on-chip loopback source. Frame format: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data, MSB first.

## Interface
- CLK_DIV, 4, clk cycles per SCLK half-period (H). Legal range is 1..255. Must be ≥4 when driving the on-chip peripheral, so its SCLK synchroniser sees every edge.
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset; one clock, sampled on clk rising edge
- start  input  1  request; sampled only when busy=0
- rw  input  1  frame bit 15; captured with start
- addr  input  7  frame bits 14:8; captured with start
- wdata  input  8  frame bits 7:0; captured with start
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle pulse at frame completion
- nCS  output  1  chip select, active low
- SCLK  output  1  serial clock, idles low
- COPI  output  1  serial data, MSB first

## Operation
- All outputs are registered. Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, state IDLE, shift register and counters 0.
- States are IDLE, SETUP, SHIFT, HOLD and GAP.
- IDLE: when start=1 at a clock edge (edge E0), capture {rw,addr,wdata} into a 16-bit shift register. At the same edge set nCS=0, COPI=rw, busy=1, and go to SETUP.
- SETUP: wait H cycles with SCLK=0, then drive SCLK to 1 and go to SHIFT.
- SHIFT: SCLK toggles every H cycles. On each falling edge except the 16th, COPI advances to the next lower bit. A 5-bit bit counter counts rising edges. The 16th falling edge moves to HOLD with SCLK=0, and COPI holds bit 0.
- HOLD: wait H cycles, then nCS=1, COPI=0, and go to GAP.
- GAP: wait H cycles, then assert done=1 for 1 cycle, drop busy to 0, and return to IDLE.
- start asserted while busy=1 is ignored; it is neither queued nor able to corrupt the captured data. Input changes after capture have no effect.
- rw=0 frames are transmitted unchanged; the peripheral discards them.
- Divider: an 8-bit half-period counter that reloads at every phase transition. For CLK_DIV=1, SCLK toggles every cycle.
- Reset mid-frame: outputs return to reset values at that edge. The truncated frame (<16 rising edges) is discarded by the peripheral, and no done pulse is generated.

## Timing
- Times are in clk edges relative to E0; H = CLK_DIV.
- E0: nCS↓, busy↑, COPI = bit 15.
- Rising edge k (k=1..16) at E0+(2k−1)H; falling edge k at E0+2kH.
- COPI = bit 15−k from E0+2kH for k=1..15. Data is therefore stable for ≥H cycles either side of every rising edge.
- nCS↑ at E0+33H: nCS is low for exactly 33H cycles, giving H cycles of setup before the first rise and H cycles of hold after the last fall.
- done=1 and busy=0 in the cycle following edge E0+34H.
- A start held high in that cycle is accepted at edge E0+34H+1. Minimum nCS-high gap between back-to-back frames is H+1 cycles.
- Latency from start acceptance to done is 34H+1 cycles: 137 at H=4.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → nCS=1, SCLK=0, COPI=0, busy=0, done=0 throughout; no frame is started.
- Single write, CLK_DIV=4, rw=1, addr=0x00, wdata=0xF0:
  - Exactly 16 SCLK rises are sampled, giving 0x80F0.
  - nCS is low for 132 cycles, done pulses once at cycle 137, and the peripheral's en_reg_out_7_0 reads 0xF0.
- Back-to-back writes, start held high: addr=0x04 data=0x80, then addr=0x02 data=0xFF.
  - Two frames are sent (0x8480, 0x82FF) with a 5-cycle nCS-high gap.
  - Peripheral pwm_duty_cycle=0x80 and en_reg_pwm_7_0=0xFF.
- start pulsed at rising edge 5 of an active frame with different addr/data → the frame is unchanged, there is no second frame, and busy stays high continuously until a single done pulse.
- rst_n=0 for 1 cycle after rising edge 8 → nCS=1 and SCLK=0 on the next edge, with no done pulse. A following write addr=0x01 data=0x55 still lands correctly, giving en_reg_out_15_8=0x55.
- CLK_DIV=1, wdata=0xA5 → SCLK toggles every cycle, COPI matches 0x80A5 sampled on rising edges, and done arrives 35 cycles after acceptance.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write initiator.
// Accepts one {rw, addr, wdata} request while idle and serialises it MSB first
// as a 16-bit frame on nCS/SCLK/COPI. SCLK half-period is CLK_DIV clk cycles.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start             request, sampled only while busy = 0
//   rw, addr, wdata   frame bit 15, bits 14:8, bits 7:0 (captured with start)
//   busy              high from acceptance until done
//   done              one-cycle pulse at frame completion
//   nCS, SCLK, COPI   SPI chip select (active low), clock (idles low), data
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 5;
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               busy_d, done_d, ncs_d, sclk_d, copi_d;
  logic               div_zero;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nCS     <= 1'b1;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      busy    <= busy_d;
      done    <= done_d;
      nCS     <= ncs_d;
      SCLK    <= sclk_d;
      COPI    <= copi_d;
    end
  end

  // Next-state and next-output logic; every phase lasts one half-period
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    div_d    = div_q;
    bit_d    = bit_q;
    busy_d   = busy;
    done_d   = 1'b0;
    ncs_d    = nCS;
    sclk_d   = SCLK;
    copi_d   = COPI;
    div_zero = (div_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {rw, addr, wdata};
          ncs_d   = 1'b0;
          copi_d  = rw;
          busy_d  = 1'b1;
          div_d   = HALF_RELOAD;
          bit_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          bit_d   = BIT_W'(1);
          div_d   = HALF_RELOAD;
          state_d = SHIFT;
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      SHIFT: begin
        if (div_zero) begin
          div_d = HALF_RELOAD;
          if (!SCLK) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_W'(1);
          end else begin
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              // Rotate rather than shift so the register never loses a bit;
              // the next COPI bit is always sitting just below the MSB.
              sr_d   = {sr_q[FRAME_W-2:0], sr_q[FRAME_W-1]};
              copi_d = sr_q[FRAME_W-2];
            end
          end
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      HOLD: begin
        if (div_zero) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          div_d   = HALF_RELOAD;
          state_d = GAP;
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (div_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          bit_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
